// File: rtl/mem_access_pkg.sv
// Shared types for the MEM pipeline stage: stage registers, funct3 encodings, FSM states.
// The optional misaligned-access trap (MEM_MISALIGN_TRAP_EN) uses is_misaligned below.
package mem_access_pkg;

    localparam int unsigned WIDTH = 32;

    typedef logic [WIDTH-1:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    typedef struct packed {
        rv32i_word  pc;
        rv32i_word  alu;
        rv32i_word  rs2;
        rv32i_word  mdr;
        logic [4:0] rd;
        logic [2:0] funct3;
        ctrl_t      ctrl;
        logic       valid;
    } stage_regs;

    // Access size lives in funct3[1:0] for both loads and stores: 01 = half, 10 = word.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
        return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_access_if;
    import mem_access_pkg::*;

    logic       dmem_read;
    logic       dmem_write;
    rv32i_word  dmem_address;
    rv32i_word  dmem_wdata;
    logic [3:0] dmem_byte_enable;
    rv32i_word  dmem_rdata;
    logic       dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load extraction: picks the addressed byte/half from the read word and extends it.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_off,
    input  rv32i_word  i_rdata,
    output rv32i_word  o_mdr
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_mdr = i_rdata;
        case (i_funct3)
            lb:      o_mdr = {{24{w_byte[7]}}, w_byte};
            lbu:     o_mdr = {24'b0, w_byte};
            lh:      o_mdr = {{16{w_half[15]}}, w_half};
            lhu:     o_mdr = {16'b0, w_half};
            lw:      o_mdr = i_rdata;
            default: o_mdr = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Pipeline stage 4 (MEM): issues one data-memory access per memop and stalls upstream until resp.
// Define MEM_MISALIGN_TRAP_EN to drop misaligned half/word accesses and pulse misalign_o instead.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  stage_regs           regs_in,
    output stage_regs           regs_out,
    output logic                stall_o,
    mem_access_if.master        dmem
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                misalign_o
`endif
);

    mem_state_t       r_state;
    logic             w_memop;
    logic             w_misaligned;
    logic             w_start;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [width-1:0] w_wdata;
    logic [width-1:0] w_addr;
    rv32i_word        w_mdr;

    assign w_off   = regs_in.alu[1:0];
    assign w_addr  = {regs_in.alu[31:2], 2'b00};
    assign w_memop = regs_in.valid & (regs_in.ctrl.mem_read | regs_in.ctrl.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = is_misaligned(regs_in.funct3[1:0], w_off);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_start = w_memop & ~w_misaligned;

    // Lanes keyed on funct3[1:0] so unsigned loads get the same mask as their signed forms.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = regs_in.rs2;
        case (regs_in.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{regs_in.rs2[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{regs_in.rs2[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = regs_in.rs2;
            end
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            IDLE:    stall_o = w_start;
            BUSY:    stall_o = ~dmem.dmem_resp;
            default: stall_o = 1'b0;
        endcase
    end

    // regs_in is held by the stall while BUSY, so it still describes the outstanding access.
    mem_access_load_align u_load_align (
        .i_funct3 (regs_in.funct3),
        .i_off    (w_off),
        .i_rdata  (dmem.dmem_rdata),
        .o_mdr    (w_mdr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= IDLE;
            regs_out              <= '0;
            dmem.dmem_read        <= 1'b0;
            dmem.dmem_write       <= 1'b0;
            dmem.dmem_address     <= '0;
            dmem.dmem_wdata       <= '0;
            dmem.dmem_byte_enable <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o            <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    regs_out     <= regs_in;
                    regs_out.mdr <= '0;
                    if (w_start) begin
                        regs_out.valid        <= 1'b0;
                        dmem.dmem_read        <= regs_in.ctrl.mem_read;
                        dmem.dmem_write       <= regs_in.ctrl.mem_write;
                        dmem.dmem_address     <= w_addr;
                        dmem.dmem_wdata       <= w_wdata;
                        dmem.dmem_byte_enable <= w_be;
                        r_state               <= BUSY;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (w_memop) begin
                        regs_out.valid <= 1'b0;
                        misalign_o     <= 1'b1;
                    end
`endif
                end
                BUSY: begin
                    regs_out.valid <= 1'b0;
                    if (dmem.dmem_resp) begin
                        regs_out        <= regs_in;
                        regs_out.mdr    <= w_mdr;
                        dmem.dmem_read  <= 1'b0;
                        dmem.dmem_write <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected outputs/requests, monitors compare.
// Define MEM_MISALIGN_TRAP_EN to also exercise the misaligned-access trap.
module tb_mem_access;
    import mem_access_pkg::*;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic      clk = 1'b0;
    logic      rst;
    stage_regs regs_in;
    stage_regs regs_out;
    logic      stall_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic      misalign_o;
`endif

    mem_access_if dmem_bus ();

    mem_access #(.width(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .regs_in  (regs_in),
        .regs_out (regs_out),
        .stall_o  (stall_o),
        .dmem     (dmem_bus)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int        checks   = 0;
    int        failures = 0;
    stage_regs exp_q[$];
    req_t      req_q[$];
    req_t      cur_req;
    req_t      now_req;
    req_t      prev_req;
    req_t      cmp_req;
    logic      prev_act    = 1'b0;
    logic      now_act;
    logic      expect_drop = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stage_regs mk(input logic [31:0] alu, input logic [31:0] rs2,
                                     input logic [2:0] f3, input logic rd_en, input logic wr_en);
        stage_regs r;
        r                = '0;
        r.pc             = 32'h0000_0400 + alu;
        r.alu            = alu;
        r.rs2            = rs2;
        r.mdr            = 32'hA5A5_A5A5;
        r.rd             = 5'd7;
        r.funct3         = f3;
        r.ctrl.reg_write = ~wr_en;
        r.ctrl.mem_read  = rd_en;
        r.ctrl.mem_write = wr_en;
        r.valid          = 1'b1;
        return r;
    endfunction

    function automatic req_t mkreq(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        req_t q;
        q.rd = rd; q.wr = wr; q.addr = addr; q.wdata = wdata; q.be = be;
        return q;
    endfunction

    // Output monitor: every valid regs_out must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && regs_out.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h expected no valid output", regs_out);
            end else begin
                check("regs_out", 160'(regs_out), 160'(exp_q.pop_front()));
            end
        end
    end

    // Request monitor: new requests match the queue, active ones stay stable, completed ones drop.
    always @(negedge clk) begin
        now_req = {dmem_bus.dmem_read, dmem_bus.dmem_write, dmem_bus.dmem_address,
                   dmem_bus.dmem_wdata, dmem_bus.dmem_byte_enable};
        now_act = now_req.rd | now_req.wr;
        if (expect_drop) begin
            check("req_drop", 160'(now_act), 160'(0));
            expect_drop = 1'b0;
        end
        if (now_act && !prev_act) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got %0h expected no request", now_req);
            end else begin
                cur_req = req_q.pop_front();
                cmp_req = now_req;
                if (!cur_req.wr) begin
                    cmp_req.wdata = cur_req.wdata;
                    cmp_req.be    = cur_req.be;
                end
                check("dmem_req", 160'(cmp_req), 160'(cur_req));
            end
        end else if (now_act) begin
            check("dmem_hold", 160'(now_req), 160'(prev_req));
        end
        prev_act = now_act;
        prev_req = now_req;
    end

    task automatic alu_op(input stage_regs r, input logic pulse_resp);
        stage_regs e;
        e     = r;
        e.mdr = '0;
        exp_q.push_back(e);
        regs_in            = r;
        dmem_bus.dmem_resp = pulse_resp;
        @(negedge clk);
        check("alu_stall", 160'(stall_o), 160'(0));
        @(posedge clk);
        #1;
        regs_in            = '0;
        dmem_bus.dmem_resp = 1'b0;
    endtask

    task automatic mem_op(input stage_regs r, input int delay, input logic [31:0] rdata,
                          input logic [31:0] exp_mdr, input req_t exp_req);
        stage_regs e;
        int        stalls;
        e      = r;
        e.mdr  = exp_mdr;
        stalls = 0;
        req_q.push_back(exp_req);
        exp_q.push_back(e);
        regs_in = r;
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            @(posedge clk);
            #1;
        end
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        @(negedge clk);
        if (stall_o) stalls++;
        @(posedge clk);
        #1;
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        regs_in             = '0;
        expect_drop         = 1'b1;
        check("stall_cycles", 160'(stalls), 160'(delay + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stage_regs r;
        rst                 = 1'b1;
        regs_in             = '0;
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_regs_out", 160'(regs_out), 160'(0));
        check("reset_dmem", 160'({dmem_bus.dmem_read, dmem_bus.dmem_write, dmem_bus.dmem_address,
                                  dmem_bus.dmem_wdata, dmem_bus.dmem_byte_enable}), 160'(0));
        check("reset_stall", 160'(stall_o), 160'(0));
        @(posedge clk);
        #1;

        alu_op(mk(32'h0000_1234, 32'h55, 3'b000, 1'b0, 1'b0), 1'b1);
        mem_op(mk(32'h0000_1003, 32'h0, 3'b000, 1'b1, 1'b0), 3, 32'h80FF_FF00,
               32'hFFFF_FF80, mkreq(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b1000));
        mem_op(mk(32'h0000_2002, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1), 2, 32'h0,
               32'h0, mkreq(1'b0, 1'b1, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100));
        mem_op(mk(32'h0000_3002, 32'h0, 3'b101, 1'b1, 1'b0), 1, 32'h8001_0000,
               32'h0000_8001, mkreq(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b1100));
        mem_op(mk(32'h0000_3000, 32'h0, 3'b001, 1'b1, 1'b0), 0, 32'h1234_8001,
               32'hFFFF_8001, mkreq(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b0011));
        mem_op(mk(32'h0000_1001, 32'h0, 3'b100, 1'b1, 1'b0), 1, 32'h1234_5678,
               32'h0000_0056, mkreq(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'b0010));
        mem_op(mk(32'h0000_2001, 32'h0000_00EF, 3'b000, 1'b0, 1'b1), 0, 32'h0,
               32'h0, mkreq(1'b0, 1'b1, 32'h0000_2000, 32'hEFEF_EFEF, 4'b0010));
        mem_op(mk(32'h0000_2004, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1), 1, 32'h0,
               32'h0, mkreq(1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111));
        mem_op(mk(32'h0000_3004, 32'h0, 3'b010, 1'b1, 1'b0), 2, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, mkreq(1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'b1111));
        alu_op(mk(32'h0000_0099, 32'h1, 3'b111, 1'b0, 1'b0), 1'b0);

        // Abandon an outstanding load with reset; the late response must not produce output.
        r = mk(32'h0000_5000, 32'h0, 3'b010, 1'b1, 1'b0);
        req_q.push_back(mkreq(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b1111));
        regs_in = r;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        regs_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_read", 160'(dmem_bus.dmem_read), 160'(0));
        check("rst_busy_valid", 160'(regs_out.valid), 160'(0));
        check("rst_busy_stall", 160'(stall_o), 160'(0));
        @(posedge clk);
        #1;
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        alu_op(mk(32'h0000_0042, 32'h2, 3'b000, 1'b0, 1'b0), 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        regs_in = mk(32'h0000_4001, 32'h0, 3'b010, 1'b1, 1'b0);
        @(negedge clk);
        check("mis_stall", 160'(stall_o), 160'(0));
        @(posedge clk);
        #1;
        regs_in = '0;
        @(negedge clk);
        check("mis_pulse", 160'(misalign_o), 160'(1));
        check("mis_valid", 160'(regs_out.valid), 160'(0));
        check("mis_alu", 160'(regs_out.alu), 160'(32'h0000_4001));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mis_pulse_end", 160'(misalign_o), 160'(0));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 160'(exp_q.size()), 160'(0));
        check("req_q_drained", 160'(req_q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
